// File: rtl/riscv_nn_fetch_req_ctrl.sv
// riscv_nn_fetch_req_ctrl
//   Instruction-fetch request controller for the IF stage. It issues
//   word-aligned requests on a req/gnt/rvalid memory port and keeps at most
//   one request outstanding. Returned words are pushed into the fetch FIFO
//   together with their address. Branch redirects clear the FIFO. Hardware-loop
//   redirects replace the FIFO's second entry. Responses that belong to an
//   address already superseded by a redirect are dropped.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_i              fetching enabled
//   branch_i/_addr_i   single-cycle branch redirect and its target
//   hwlp_jump_i        single-cycle hardware-loop redirect
//   hwlp_target_i      hardware-loop target
//   instr_*            memory request/grant/response port
//   fifo_*             FIFO push port plus clear/replace2 control
//   busy_o             controller is not idle
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | no request outstanding, waiting for a redirect or can_issue
// WAIT_GNT    | request asserted on the memory port, waiting for grant
// WAIT_RVALID | request granted, waiting for the response to push
// ABORTED     | granted request is stale; its response is dropped
module riscv_nn_fetch_req_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_jump_i,
    input  logic [31:0] hwlp_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic        fifo_replace2_o,
    output logic        fifo_is_hwlp_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        ABORTED     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        started_q, started_d;
    logic        hwlp_pend_q, hwlp_pend_d;

    logic        redirect;
    logic        can_issue;
    logic        can_issue_after_push;
    logic        push;

    assign redirect  = branch_i | hwlp_jump_i;
    assign can_issue = started_q & req_i & (fifo_ready_i | hwlp_pend_q);
    // After a push hwlp_pend is cleared, so only fifo_ready_i can enable the
    // next issue.
    assign can_issue_after_push = started_q & req_i & fifo_ready_i;

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    if (req_i) state_d = WAIT_GNT;
                end else if (can_issue) begin
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                // The granted address is the old one if a redirect lands in the
                // same cycle, so its response must be dropped.
                if (instr_gnt_i) state_d = redirect ? ABORTED : WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    if (redirect) begin
                        state_d = req_i ? WAIT_GNT : IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = can_issue_after_push ? WAIT_GNT : IDLE;
                    end
                end else if (redirect) begin
                    state_d = ABORTED;
                end
            end
            ABORTED: begin
                if (instr_rvalid_i) state_d = (req_i & started_q) ? WAIT_GNT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        started_d    = started_q;
        hwlp_pend_d  = hwlp_pend_q;

        if (branch_i) begin
            fetch_addr_d = {branch_addr_i[31:1], 1'b0};
            hwlp_pend_d  = 1'b0;
            started_d    = 1'b1;
        end else if (hwlp_jump_i) begin
            fetch_addr_d = hwlp_target_i;
            hwlp_pend_d  = 1'b1;
        end else if (push) begin
            fetch_addr_d = {fetch_addr_q[31:2] + 30'd1, 2'b00};
            hwlp_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= 32'd0;
            started_q    <= 1'b0;
            hwlp_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            started_q    <= started_d;
            hwlp_pend_q  <= hwlp_pend_d;
        end
    end

    // Reset overrides the combinational outputs too, so nothing leaks out
    // while the registers are still being cleared.
    assign instr_req_o     = (state_q == WAIT_GNT) & ~rst;
    assign instr_addr_o    = {fetch_addr_q[31:2], 2'b00};
    assign fifo_addr_o     = fetch_addr_q;
    assign fifo_rdata_o    = instr_rdata_i;
    assign fifo_valid_o    = push & ~rst;
    assign fifo_clear_o    = branch_i & ~rst;
    assign fifo_replace2_o = push & hwlp_pend_q & ~rst;
    assign fifo_is_hwlp_o  = push & hwlp_pend_q & ~rst;
    assign busy_o          = (state_q != IDLE) & ~rst;

endmodule
